// File: rtl/credits_pkg.sv
// credits_pkg: ASCII constants, scroller FSM encoding and a string-slice helper
// shared by the credits scroller and its text ROM.
package credits_pkg;
  localparam logic [6:0] CH_BLANK = 7'h20;
  localparam logic [6:0] CH_COLON = 7'h3a;
  localparam logic [6:0] CH_0     = 7'h30;
  localparam logic [6:0] CH_9     = 7'h39;
  localparam logic [6:0] CH_A     = 7'h41;
  localparam logic [6:0] CH_B     = 7'h42;
  localparam logic [6:0] CH_C     = 7'h43;
  localparam logic [6:0] CH_J     = 7'h4a;
  localparam logic [6:0] CH_M     = 7'h4d;
  localparam logic [6:0] CH_Z     = 7'h5a;
  localparam int LINE_CHARS = 16;
  typedef enum logic [1:0] {ST_IDLE, ST_PAUSE, ST_SCROLL, ST_DONE} state_t;
  typedef logic [8*LINE_CHARS-1:0] line_str_t;
  // String literals pack the leftmost character in the top byte.
  function automatic logic [6:0] char_at(input line_str_t s, input int c);
    return (c >= 0 && c < LINE_CHARS) ? s[8*(LINE_CHARS-1-c) +: 7] : CH_BLANK;
  endfunction
endpackage

// File: rtl/credits_text_rom.sv
// credits_text_rom: combinational credit text lookup by line and column;
// anything outside the stored text reads as a blank.
module credits_text_rom
  import credits_pkg::*;
#(
  parameter int COLS       = 16,
  parameter int TEXT_LINES = 6,
  parameter int COL_W      = $clog2(COLS),
  parameter int LINE_W     = $clog2(TEXT_LINES+1)
) (
  input  logic [LINE_W-1:0] line,
  input  logic [COL_W-1:0]  col,
  output logic [6:0]        code
);
  localparam line_str_t L0    = "   Created by:  ";
  localparam line_str_t L2    = "    Bartosz     ";
  localparam line_str_t L3    = "   Bialkowski   ";
  localparam line_str_t L4    = "    Mateusz     ";
  localparam line_str_t L5    = "   Jagielski    ";
  localparam line_str_t BLANK = "                ";
  line_str_t sel;
  always_comb begin
    case (int'(line))
      0: sel = L0;
      2: sel = L2;
      3: sel = L3;
      4: sel = L4;
      5: sel = L5;
      default: sel = BLANK;
    endcase
    code = char_at(sel, int'(col));
  end
endmodule

// File: rtl/credits_scroller.sv
// credits_scroller: holds the credit text on the first page, then scrolls it up
// one pixel row per frame; serves registered character lookups to the renderer.
module credits_scroller
  import credits_pkg::*;
#(
  parameter int COLS        = 16,
  parameter int ROWS        = 2,
  parameter int TEXT_LINES  = 6,
  parameter int CHAR_H      = 16,
  parameter int HOLD_FRAMES = 60,
  parameter int COL_W       = $clog2(COLS),
  parameter int ROW_W       = $clog2(ROWS+1),
  parameter int LINE_W      = $clog2(TEXT_LINES+1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
  input  logic                      loop_en,
  input  logic                      frame_tick,
  input  logic [ROW_W-1:0]          row,
  input  logic [COL_W-1:0]          col,
  output logic [6:0]                char_code,
  output logic [$clog2(CHAR_H)-1:0] fine_ofs,
  output logic                      busy,
  output logic                      done
);
  localparam int FINE_W = $clog2(CHAR_H);
  localparam int HOLD_W = $clog2(HOLD_FRAMES+1);
  state_t state_q, state_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [FINE_W-1:0] fine_q, fine_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [6:0] char_q, char_d, rom_code;
  logic [LINE_W:0] text_line;
  logic last_hold, fine_wrap, text_end;
  assign last_hold = hold_q == HOLD_W'(HOLD_FRAMES-1);
  assign fine_wrap = fine_q == FINE_W'(CHAR_H-1);
  assign text_end  = line_q == LINE_W'(TEXT_LINES-1);
  assign busy      = state_q == ST_PAUSE || state_q == ST_SCROLL;
  assign done      = state_q == ST_DONE;
  assign fine_ofs  = fine_q;
  assign char_code = char_q;
  // One extra bit so rows below the last text line cannot wrap back to the top.
  assign text_line = {1'b0, line_q} + (LINE_W+1)'(row);
  credits_text_rom #(
    .COLS(COLS), .TEXT_LINES(TEXT_LINES), .COL_W(COL_W), .LINE_W(LINE_W)
  ) u_rom (
    .line(text_line[LINE_W-1:0]),
    .col (col),
    .code(rom_code)
  );
  assign char_d = (busy && text_line < (LINE_W+1)'(TEXT_LINES)) ? rom_code : CH_BLANK;
  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    fine_d  = fine_q;
    hold_d  = hold_q;
    if (abort || start) begin
      state_d = abort ? ST_IDLE : ST_PAUSE;
      line_d  = '0;
      fine_d  = '0;
      hold_d  = '0;
    end else if (frame_tick && state_q == ST_PAUSE) begin
      hold_d  = last_hold ? '0 : hold_q + 1'b1;
      state_d = last_hold ? ST_SCROLL : ST_PAUSE;
    end else if (frame_tick && state_q == ST_SCROLL) begin
      fine_d = fine_wrap ? '0 : fine_q + 1'b1;
      if (fine_wrap) begin
        line_d  = (text_end && loop_en) ? '0 : line_q + 1'b1;
        state_d = !text_end ? ST_SCROLL : loop_en ? ST_PAUSE : ST_DONE;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      line_q  <= '0;
      fine_q  <= '0;
      hold_q  <= '0;
      char_q  <= CH_BLANK;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      fine_q  <= fine_d;
      hold_q  <= hold_d;
      char_q  <= char_d;
    end
  end
endmodule

// File: tb/tb_credits_scroller.sv
// tb_credits_scroller: directed stimulus with a queued-expectation scoreboard
// for the credits scroller (HOLD_FRAMES shortened to 3).
module tb_credits_scroller;
  logic clk = 0, rst = 1, start = 0, abort = 0, loop_en = 0, frame_tick = 0;
  logic [1:0] row = 0;
  logic [3:0] col = 0;
  logic [6:0] char_code;
  logic [3:0] fine_ofs;
  logic busy, done;
  int checks = 0, failures = 0, cyc = 0;
  bit done_seen = 0;
  typedef struct {
    string name;
    int due;
    logic [6:0] ch;
    logic [3:0] fine;
    logic busy;
    logic done;
  } exp_t;
  exp_t q[$];

  credits_scroller #(
    .COLS(16), .ROWS(2), .TEXT_LINES(6), .CHAR_H(16), .HOLD_FRAMES(3)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .loop_en(loop_en),
    .frame_tick(frame_tick), .row(row), .col(col), .char_code(char_code),
    .fine_ofs(fine_ofs), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (done) done_seen = 1;

  task automatic check(input string name, input logic [6:0] ec, input logic [3:0] ef,
                       input logic eb, input logic ed);
    checks++;
    if (char_code !== ec || fine_ofs !== ef || busy !== eb || done !== ed) begin
      failures++;
      $display("FAIL %s: got char=%h fine=%0d busy=%b done=%b, expected char=%h fine=%0d busy=%b done=%b",
               name, char_code, fine_ofs, busy, done, ec, ef, eb, ed);
    end
  endtask

  always @(posedge clk) begin : mon
    exp_t e;
    #2;
    if (q.size() != 0 && cyc >= q[0].due) begin
      e = q.pop_front();
      check(e.name, e.ch, e.fine, e.busy, e.done);
    end
  end

  // All stimulus tasks are entered and left on a falling edge.
  task automatic rd(input logic [1:0] r, input logic [3:0] c, input logic [6:0] ec,
                    input logic [3:0] ef, input logic eb, input logic ed, input string name);
    exp_t e;
    row = r;
    col = c;
    e.name = name; e.due = cyc + 1; e.ch = ec; e.fine = ef; e.busy = eb; e.done = ed;
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      frame_tick = 1;
      @(negedge clk);
      frame_tick = 0;
    end
  endtask

  task automatic pulse_start();
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_state", 7'h20, 0, 0, 0);
    rst = 0;
    rd(0, 3, 7'h20, 0, 0, 0, "idle_read");
    pulse_start();
    rd(0, 3, 7'h43, 0, 1, 0, "pause_row0_C");
    rd(1, 3, 7'h20, 0, 1, 0, "pause_row1_blank");
    tick(3);
    rd(0, 3, 7'h43, 0, 1, 0, "scroll_entry_fine0");
    tick(1);
    rd(0, 3, 7'h43, 1, 1, 0, "scroll_fine1");
    tick(15);
    rd(0, 3, 7'h20, 0, 1, 0, "line1_row0_blank");
    rd(1, 4, 7'h42, 0, 1, 0, "line1_row1_B");
    tick(16);
    rd(0, 4, 7'h42, 0, 1, 0, "line2_row0_B");
    rd(2, 4, 7'h4d, 0, 1, 0, "line2_row2_M");
    rd(1, 3, 7'h42, 0, 1, 0, "line2_row1_Bialk");
    tick(5);
    rd(0, 4, 7'h42, 5, 1, 0, "line2_fine5");
    tick(58);
    rd(0, 3, 7'h4a, 15, 1, 0, "line5_row0_J");
    rd(1, 3, 7'h20, 15, 1, 0, "past_end_blank");
    tick(1);
    rd(0, 3, 7'h20, 0, 0, 1, "done_blank");
    rd(2, 4, 7'h20, 0, 0, 1, "done_blank_row2");
    pulse_start();
    rd(0, 3, 7'h43, 0, 1, 0, "restart_from_done");
    loop_en = 1;
    done_seen = 0;
    tick(3 + 96);
    rd(0, 3, 7'h43, 0, 1, 0, "loop_back_line0");
    tick(1);
    rd(0, 3, 7'h43, 0, 1, 0, "loop_in_pause");
    checks++;
    if (done_seen !== 1'b0) begin
      failures++;
      $display("FAIL loop_no_done: done_seen=%b expected 0", done_seen);
    end
    abort = 1;
    start = 1;
    @(negedge clk);
    abort = 0;
    start = 0;
    rd(0, 3, 7'h20, 0, 0, 0, "abort_beats_start");
    loop_en = 0;
    pulse_start();
    tick(3 + 4);
    rd(0, 3, 7'h43, 4, 1, 0, "pre_restart_fine4");
    start = 1;
    frame_tick = 1;
    @(negedge clk);
    start = 0;
    frame_tick = 0;
    rd(0, 3, 7'h43, 0, 1, 0, "tick_with_start");
    tick(3);
    rd(0, 3, 7'h43, 0, 1, 0, "three_ticks_to_scroll");
    tick(1);
    rd(0, 3, 7'h43, 1, 1, 0, "scroll_after_restart");
    tick(2);
    #2 rst = 1;
    #1 check("async_reset_mid_scroll", 7'h20, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    rd(0, 3, 7'h20, 0, 0, 0, "idle_after_reset");
    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    #5;
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
